// File: rtl/sb_cfg_pkg.sv
// Shared types and helpers for the switch-block configuration loader.
// The CRC helper is only referenced when SB_CFG_READBACK_EN is defined.
package sb_cfg_pkg;

    localparam int unsigned SB_CFG_BITS = 32;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        VERIFY,
        DONE
    } sb_state_e;

    // CRC-16, MSB-first, one data bit per call
    function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic din,
                                               input logic [15:0] poly);
        logic fb;
        fb = crc[15] ^ din;
        return {crc[14:0], 1'b0} ^ (fb ? poly : 16'h0000);
    endfunction

endpackage

// File: rtl/sb_cfg_shifter.sv
// 32-bit load/shift-right holding register feeding the chain LSB-first.
// Tracks bits sent so the controller knows when the word is empty or on its last bit.
module sb_cfg_shifter
    import sb_cfg_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_clear,
    input  logic                   i_load,
    input  logic [SB_CFG_BITS-1:0] i_data,
    input  logic                   i_shift,
    output logic                   o_bit,
    output logic                   o_empty,
    output logic                   o_last
);
    localparam int unsigned BIT_CNT_W = $clog2(SB_CFG_BITS);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(SB_CFG_BITS - 1);

    logic [SB_CFG_BITS-1:0] r_data;
    logic [BIT_CNT_W-1:0]   r_bit_cnt;
    logic                   r_full;

    // A load on the last shift cycle replaces the word with no bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data    <= '0;
            r_bit_cnt <= '0;
            r_full    <= 1'b0;
        end else if (i_clear) begin
            r_data    <= '0;
            r_bit_cnt <= '0;
            r_full    <= 1'b0;
        end else if (i_load) begin
            r_data    <= i_data;
            r_bit_cnt <= '0;
            r_full    <= 1'b1;
        end else if (i_shift && r_full) begin
            r_data    <= {1'b0, r_data[SB_CFG_BITS-1:1]};
            r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
            if (r_bit_cnt == LAST_BIT) begin
                r_full <= 1'b0;
            end
        end
    end

    assign o_bit   = r_data[0];
    assign o_empty = !r_full;
    assign o_last  = r_full && (r_bit_cnt == LAST_BIT);

endmodule

// File: rtl/sb_cfg_loader.sv
// Loads NUM_SB 32-bit words LSB-first into a switch-block daisy chain (first word ends at tail).
// Define SB_CFG_READBACK_EN to add a CRC-16 circular readback verify pass and cfg_err.
module sb_cfg_loader
    import sb_cfg_pkg::*;
#(
    parameter int unsigned NUM_SB   = 4,
    parameter int unsigned WORD_W   = 32,
    parameter logic [15:0] CRC_POLY = 16'h1021
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_start,
    input  logic                        i_cfg_valid,
    input  logic [WORD_W-1:0]           i_cfg_data,
    output logic                        o_cfg_ready,
    input  logic                        i_chain_in,
    output logic                        o_prog_data,
    output logic                        o_prog_en,
    output logic                        o_busy,
    output logic                        o_done,
    output logic [$clog2(NUM_SB+1)-1:0] o_word_cnt,
    output logic                        o_cfg_err
);
    localparam int unsigned CNT_W   = $clog2(NUM_SB + 1);
    localparam int unsigned TOTAL   = SB_CFG_BITS * NUM_SB;
    localparam int unsigned SHIFT_W = $clog2(TOTAL);
    localparam logic [SHIFT_W-1:0] LAST_SHIFT = SHIFT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0]   NUM_WORDS  = CNT_W'(NUM_SB);

    if (WORD_W != SB_CFG_BITS) begin : g_word_w_check
        $error("sb_cfg_loader: WORD_W must be 32");
    end

    sb_state_e          r_state;
    logic               r_busy;
    logic               r_done;
    logic [CNT_W-1:0]   r_word_cnt;
    logic [SHIFT_W-1:0] r_shift_cnt;

    logic w_empty, w_last, w_sh_bit;
    logic w_start, w_ready, w_accept, w_load_shift, w_load_end, w_verify_end;

    assign w_start      = (r_state == IDLE) && i_start;
    assign w_ready      = (r_state == LOAD) && (w_empty || w_last) && (r_word_cnt != NUM_WORDS);
    assign w_accept     = w_ready && i_cfg_valid;
    assign w_load_shift = (r_state == LOAD) && !w_empty;
    assign w_load_end   = w_load_shift && (r_shift_cnt == LAST_SHIFT);

    sb_cfg_shifter u_shifter (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_start),
        .i_load  (w_accept),
        .i_data  (i_cfg_data),
        .i_shift (w_load_shift),
        .o_bit   (w_sh_bit),
        .o_empty (w_empty),
        .o_last  (w_last)
    );

`ifdef SB_CFG_READBACK_EN
    logic [15:0] r_crc_tx, r_crc_rx;
    logic [15:0] w_crc_tx_nxt, w_crc_rx_nxt;
    logic        r_cfg_err;

    assign w_crc_tx_nxt = crc16_next(r_crc_tx, w_sh_bit, CRC_POLY);
    assign w_crc_rx_nxt = crc16_next(r_crc_rx, i_chain_in, CRC_POLY);
    assign w_verify_end = (r_state == VERIFY) && (r_shift_cnt == LAST_SHIFT);

    // Recirculating chain_in for one full chain length restores the loaded contents
    assign o_prog_en   = w_load_shift || (r_state == VERIFY);
    assign o_prog_data = (r_state == VERIFY) ? i_chain_in : w_sh_bit;
    assign o_cfg_err   = r_cfg_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crc_tx  <= 16'hFFFF;
            r_crc_rx  <= 16'hFFFF;
            r_cfg_err <= 1'b0;
        end else if (w_start) begin
            r_crc_tx  <= 16'hFFFF;
            r_crc_rx  <= 16'hFFFF;
            r_cfg_err <= 1'b0;
        end else begin
            if (w_load_shift) r_crc_tx <= w_crc_tx_nxt;
            if (r_state == VERIFY) r_crc_rx <= w_crc_rx_nxt;
            if (w_verify_end && (w_crc_rx_nxt != r_crc_tx)) r_cfg_err <= 1'b1;
        end
    end
`else
    logic w_unused;

    assign w_verify_end = 1'b0;
    assign o_prog_en    = w_load_shift;
    assign o_prog_data  = w_sh_bit;
    assign o_cfg_err    = 1'b0;
    assign w_unused     = i_chain_in ^ (^CRC_POLY);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_word_cnt  <= '0;
            r_shift_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state     <= LOAD;
                        r_busy      <= 1'b1;
                        r_word_cnt  <= '0;
                        r_shift_cnt <= '0;
                    end
                end
                LOAD: begin
                    if (w_accept) r_word_cnt <= r_word_cnt + CNT_W'(1);
                    if (w_load_end) begin
`ifdef SB_CFG_READBACK_EN
                        r_state     <= VERIFY;
                        r_shift_cnt <= '0;
`else
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
`endif
                    end else if (w_load_shift) begin
                        r_shift_cnt <= r_shift_cnt + SHIFT_W'(1);
                    end
                end
                VERIFY: begin
                    if (w_verify_end) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_shift_cnt <= r_shift_cnt + SHIFT_W'(1);
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_cfg_ready = w_ready;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_word_cnt  = r_word_cnt;

endmodule

// File: tb/tb_sb_cfg_loader.sv
// Self-checking bench for sb_cfg_loader with a behavioural 4-block chain model.
// Readback scenarios are compiled in when SB_CFG_READBACK_EN is defined.
module tb_sb_cfg_loader;
    localparam int NSB   = 4;
    localparam int TOTAL = 32 * NSB;
`ifdef SB_CFG_READBACK_EN
    localparam int VERIFY_CYC = TOTAL;
`else
    localparam int VERIFY_CYC = 0;
`endif
    localparam int WC_W = $clog2(NSB + 1);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            cfg_valid = 1'b0;
    logic [31:0]     cfg_data = '0;
    logic            cfg_ready, chain_in, prog_data, prog_en, busy, done, cfg_err;
    logic [WC_W-1:0] word_cnt;

    logic [TOTAL-1:0] chain = '0;
    logic             flip = 1'b0;
    logic [31:0]      words[NSB];

    int n_vec = 0;
    int n_err = 0;

    // Observations collected by run_load
    int pe_count, first_pe, last_pe, done_cycle, done_count, accepts, idle_pe;
    logic [WC_W-1:0] wc_after_start, wc_c1;
    logic busy_after_start, busy_c1, err_c1, err_at_done;

    sb_cfg_loader #(
        .NUM_SB   (NSB),
        .WORD_W   (32),
        .CRC_POLY (16'h1021)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (start),
        .i_cfg_valid (cfg_valid),
        .i_cfg_data  (cfg_data),
        .o_cfg_ready (cfg_ready),
        .i_chain_in  (chain_in),
        .o_prog_data (prog_data),
        .o_prog_en   (prog_en),
        .o_busy      (busy),
        .o_done      (done),
        .o_word_cnt  (word_cnt),
        .o_cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    // Chain of NSB 32-bit shift-right registers, SB0 in the top bits, tail bit 0 feeds chain_in
    assign chain_in = chain[0] ^ flip;
    always @(posedge clk) if (prog_en) chain <= {prog_data, chain[TOTAL-1:1]};

    function automatic logic [31:0] sb_word(input int k);
        return chain[(NSB-1-k)*32 +: 32];
    endfunction

    task automatic run_load(input int gap_after, input int gap_len, input int start_at,
                            input int flip_at, input int abort_pe);
        int idx = 0;
        int cyc = 0;
        int gap_left = gap_len;
        pe_count = 0; first_pe = -1; last_pe = -1; done_cycle = -1; done_count = 0;
        accepts = 0; idle_pe = 0; err_at_done = 1'bx;
        start = 1'b1;
        cfg_valid = 1'b0;
        while (cyc < 800) begin
            @(posedge clk); #1;
            cyc++;
            start = (cyc == start_at);
            flip  = (cyc == flip_at);
            cfg_data = (idx < NSB) ? words[idx] : $urandom;
            if (cfg_ready && idx == gap_after && gap_left > 0) begin
                gap_left--;
                cfg_valid = 1'b0;
            end else begin
                cfg_valid = 1'b1;
            end
            if (cfg_valid && cfg_ready) begin
                accepts++;
                idx++;
            end
            if (prog_en) begin
                pe_count++;
                if (first_pe < 0) first_pe = cyc;
                last_pe = cyc;
                if (!busy) idle_pe++;
            end
            if (done) begin
                done_count++;
                if (done_cycle < 0) begin
                    done_cycle  = cyc;
                    err_at_done = cfg_err;
                end
            end
            if (cyc == 1) begin
                wc_c1 = word_cnt; busy_c1 = busy; err_c1 = cfg_err;
            end
            if (cyc == start_at + 1) begin
                wc_after_start = word_cnt; busy_after_start = busy;
            end
            if (abort_pe > 0 && pe_count == abort_pe) break;
            if (done_cycle >= 0 && cyc >= done_cycle + 4) break;
        end
        cfg_valid = 1'b0;
        start = 1'b0;
        flip = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({prog_en, prog_data, cfg_ready, busy, done, cfg_err} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want 000000",
                     {prog_en, prog_data, cfg_ready, busy, done, cfg_err});
        end
        n_vec++;
        if (word_cnt !== '0) begin
            n_err++; $display("FAIL reset_word_cnt: got %0d want 0", word_cnt);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if ({prog_en, cfg_ready, busy, done} !== 4'b0) begin
            n_err++; $display("FAIL idle_outputs: got %b want 0000", {prog_en, cfg_ready, busy, done});
        end
    endtask

    task automatic test_plan_load;
        words[0] = 32'hA5A5_0001; words[1] = 32'h0000_FFFF;
        words[2] = 32'h1234_5678; words[3] = 32'hDEAD_BEEF;
        run_load(-1, 0, -1, -1, -1);
        n_vec++;
        if (busy_c1 !== 1'b1 || wc_c1 !== '0) begin
            n_err++; $display("FAIL plan_cycle1: busy %b wc %0d want busy 1 wc 0", busy_c1, wc_c1);
        end
        n_vec++;
        if (pe_count != TOTAL + VERIFY_CYC || last_pe - first_pe + 1 != pe_count) begin
            n_err++;
            $display("FAIL plan_prog_en: got %0d cycles span %0d want %0d consecutive",
                     pe_count, last_pe - first_pe + 1, TOTAL + VERIFY_CYC);
        end
        n_vec++;
        if (first_pe != 2) begin
            n_err++; $display("FAIL plan_first_shift: got cycle %0d want 2", first_pe);
        end
        n_vec++;
        if (done_cycle != 130 + VERIFY_CYC || done_count != 1) begin
            n_err++;
            $display("FAIL plan_done: got cycle %0d count %0d want cycle %0d count 1",
                     done_cycle, done_count, 130 + VERIFY_CYC);
        end
        n_vec++;
        if (accepts != NSB || word_cnt !== WC_W'(NSB)) begin
            n_err++;
            $display("FAIL plan_words: accepts %0d word_cnt %0d want %0d", accepts, word_cnt, NSB);
        end
        n_vec++;
        if (idle_pe != 0) begin
            n_err++; $display("FAIL plan_prog_en_idle: got %0d want 0", idle_pe);
        end
        n_vec++;
        if (sb_word(0) !== 32'hDEAD_BEEF || sb_word(3) !== 32'hA5A5_0001) begin
            n_err++;
            $display("FAIL plan_chain: SB0 %h SB3 %h want deadbeef a5a50001", sb_word(0), sb_word(3));
        end
        n_vec++;
        if (err_at_done !== 1'b0) begin
            n_err++; $display("FAIL plan_cfg_err: got %b want 0", err_at_done);
        end
    endtask

    task automatic test_starvation;
        run_load(2, 10, -1, -1, -1);
        n_vec++;
        if (pe_count != TOTAL + VERIFY_CYC || last_pe - first_pe + 1 != pe_count + 10) begin
            n_err++;
            $display("FAIL starve_prog_en: got %0d cycles span %0d want %0d span %0d",
                     pe_count, last_pe - first_pe + 1, TOTAL + VERIFY_CYC, TOTAL + VERIFY_CYC + 10);
        end
        n_vec++;
        if (done_cycle != 140 + VERIFY_CYC) begin
            n_err++; $display("FAIL starve_done: got %0d want %0d", done_cycle, 140 + VERIFY_CYC);
        end
        for (int k = 0; k < NSB; k++) begin
            n_vec++;
            if (sb_word(k) !== words[NSB-1-k]) begin
                n_err++; $display("FAIL starve_sb%0d: got %h want %h", k, sb_word(k), words[NSB-1-k]);
            end
        end
    endtask

    task automatic test_start_while_busy;
        for (int i = 0; i < NSB; i++) words[i] = $urandom;
        // Cycle 80 lies inside word 3: three words accepted, no handshake nearby
        run_load(-1, 0, 80, -1, -1);
        n_vec++;
        if (wc_after_start !== WC_W'(3) || busy_after_start !== 1'b1) begin
            n_err++;
            $display("FAIL busy_start: wc %0d busy %b want 3 1", wc_after_start, busy_after_start);
        end
        n_vec++;
        if (done_count != 1 || done_cycle != 130 + VERIFY_CYC) begin
            n_err++;
            $display("FAIL busy_start_done: count %0d cycle %0d want 1 %0d",
                     done_count, done_cycle, 130 + VERIFY_CYC);
        end
        for (int k = 0; k < NSB; k++) begin
            n_vec++;
            if (sb_word(k) !== words[NSB-1-k]) begin
                n_err++; $display("FAIL busy_start_sb%0d: got %h want %h", k, sb_word(k), words[NSB-1-k]);
            end
        end
    endtask

    task automatic test_reset_mid_load;
        for (int i = 0; i < NSB; i++) words[i] = $urandom;
        run_load(-1, 0, -1, -1, 50);
        n_vec++;
        if (pe_count != 50 || prog_en !== 1'b1) begin
            n_err++; $display("FAIL midreset_reach: got %0d shifts want 50 with prog_en high", pe_count);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({prog_en, busy, cfg_ready} !== 3'b000 || word_cnt !== '0) begin
            n_err++;
            $display("FAIL midreset_async: prog_en/busy/ready %b wc %0d want 000 0",
                     {prog_en, busy, cfg_ready}, word_cnt);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < NSB; i++) words[i] = $urandom;
        run_load(-1, 0, -1, -1, -1);
        n_vec++;
        if (done_cycle != 130 + VERIFY_CYC) begin
            n_err++; $display("FAIL midreset_reload_done: got %0d want %0d", done_cycle, 130 + VERIFY_CYC);
        end
        for (int k = 0; k < NSB; k++) begin
            n_vec++;
            if (sb_word(k) !== words[NSB-1-k]) begin
                n_err++; $display("FAIL midreset_sb%0d: got %h want %h", k, sb_word(k), words[NSB-1-k]);
            end
        end
    endtask

    task automatic test_random_loads;
        for (int r = 0; r < 4; r++) begin
            int ga, gl;
            for (int i = 0; i < NSB; i++) words[i] = $urandom;
            ga = $urandom_range(0, NSB - 1);
            gl = $urandom_range(1, 20);
            run_load(ga, gl, -1, -1, -1);
            n_vec++;
            if (done_cycle != 130 + gl + VERIFY_CYC || pe_count != TOTAL + VERIFY_CYC) begin
                n_err++;
                $display("FAIL random%0d_timing: done %0d shifts %0d want %0d %0d", r,
                         done_cycle, pe_count, 130 + gl + VERIFY_CYC, TOTAL + VERIFY_CYC);
            end
            for (int k = 0; k < NSB; k++) begin
                n_vec++;
                if (sb_word(k) !== words[NSB-1-k]) begin
                    n_err++;
                    $display("FAIL random%0d_sb%0d: got %h want %h", r, k, sb_word(k), words[NSB-1-k]);
                end
            end
        end
    endtask

`ifdef SB_CFG_READBACK_EN
    task automatic test_readback_error;
        for (int i = 0; i < NSB; i++) words[i] = $urandom;
        // Verify pass spans cycles 130..257; corrupt one recirculated bit in the middle
        run_load(-1, 0, -1, 170, -1);
        n_vec++;
        if (err_at_done !== 1'b1) begin
            n_err++; $display("FAIL readback_err_set: got %b want 1", err_at_done);
        end
        for (int i = 0; i < NSB; i++) words[i] = $urandom;
        run_load(-1, 0, -1, -1, -1);
        n_vec++;
        if (err_c1 !== 1'b0 || err_at_done !== 1'b0) begin
            n_err++;
            $display("FAIL readback_err_clear: after start %b at done %b want 0 0", err_c1, err_at_done);
        end
        for (int k = 0; k < NSB; k++) begin
            n_vec++;
            if (sb_word(k) !== words[NSB-1-k]) begin
                n_err++; $display("FAIL readback_sb%0d: got %h want %h", k, sb_word(k), words[NSB-1-k]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_plan_load();
        test_starvation();
        test_start_while_busy();
        test_reset_mid_load();
        test_random_loads();
`ifdef SB_CFG_READBACK_EN
        test_readback_error();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sb_cfg_loader.md
Name: sb_cfg_loader

Overview:
- Configuration controller for a daisy-chain of NUM_SB switch-block modules. Each switch block holds a 32-bit shift register that shifts right, with its prog_in entering at bit 31 and prog_out taken from bit 0.
- Accepts 32-bit configuration words over a valid/ready stream, serialises them LSB-first onto the chain and drives prog_en.
- Reports busy/done and, optionally, verifies the loaded chain by non-destructive circular readback.
- The chain's prog_clk is tied to this block's clk.

Parameters:
- NUM_SB, 4, number of switch blocks in the chain (1..64).
- WORD_W, 32, configuration bits per switch block. Fixed at 32; any other value is an elaboration error.
- CRC_POLY, 16'h1021, CRC-16 polynomial used only when readback is compiled in.

Ports:
- clk  in  1  system clock; also drives the chain's prog_clk.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse that begins a load; ignored while busy.
- cfg_valid  in  1  cfg_data is valid.
- cfg_data  in  32  configuration word for one switch block.
- cfg_ready  out  1  a word is accepted when cfg_valid && cfg_ready.
- chain_in  in  1  prog_out of the last switch block in the chain.
- prog_data  out  1  drives prog_in of the first switch block.
- prog_en  out  1  shift enable for the whole chain.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse when a load (plus verify, if compiled in) completes.
- word_cnt  out  $clog2(NUM_SB+1)  number of words accepted in the current load.
- cfg_err  out  1  sticky readback mismatch flag, cleared by start. Tied to 0 when readback is not compiled in.

Behaviour:
- Reset (async assert, sync release): state IDLE; prog_en=0, prog_data=0, cfg_ready=0, busy=0, done=0, word_cnt=0, cfg_err=0; shifter and counters cleared.
- Word order:
  - The first word accepted ends up in the switch block farthest from prog_data (chain tail).
  - The last word accepted ends up in the first switch block.
  - Within a word, bit 0 is shifted first, so it lands at shift_reg[0] after 32 shifts.
- State IDLE:
  - start -> LOAD. busy=1 and word_cnt=0 from the next cycle.
- State LOAD:
  - cfg_ready=1 when the holding shifter is empty (bit_cnt==0 and no word loaded).
  - cfg_ready is also 1 during the final shift of the current word (bit_cnt==31), so a new word can follow with zero bubble.
  - On accept: latch cfg_data and increment word_cnt. Shifting starts the next cycle with prog_en=1 and prog_data=shifter[0]; the shifter shifts right each cycle.
  - Each word occupies exactly 32 prog_en cycles. Continuous supply gives 32*NUM_SB consecutive prog_en cycles.
- Starvation: if the shifter empties and cfg_valid=0, then prog_en=0 and the chain holds. Shifting resumes on the next accept with no bits lost.
- Word NUM_SB:
  - cfg_ready is not asserted for a (NUM_SB+1)th word.
  - After its last shift, go to DONE, or to VERIFY when readback is compiled in.
- State DONE: done=1 for one cycle, busy=0, then IDLE.
- prog_en is never high outside LOAD/VERIFY.
- start while busy: ignored, with no effect on state or counters.
- Reset mid-load: prog_en drops to 0 immediately and the chain contents are undefined. Software must reissue a full load.
- The shift-cycle counter spans 0..32*NUM_SB-1 with no wrap; it must be sized so no wrap occurs at NUM_SB=64.

Optional Feature:
- Macro: SB_CFG_READBACK_EN.
- Defined: during LOAD, a CRC-16 (CRC_POLY, init 16'hFFFF, one bit per prog_en cycle) is accumulated over the bits sent on prog_data.
  - After the last shift, state VERIFY runs exactly 32*NUM_SB cycles with prog_en=1 and prog_data=chain_in. This recirculation restores the chain to its loaded contents.
  - In VERIFY, a second CRC is accumulated over chain_in.
  - At the end of VERIFY: if the two CRCs differ, set cfg_err. Then go to DONE.
  - cfg_ready=0 throughout VERIFY.
  - The done pulse occurs 32*NUM_SB cycles later than without the macro.
- Undefined: there is no VERIFY state and no CRC logic; cfg_err is tied to 0.

Decomposition:
- Package sb_cfg_pkg holds:
  - the state enum (IDLE, LOAD, VERIFY, DONE);
  - the constant SB_CFG_BITS=32;
  - the CRC-16 next-state function (1-bit input).
- One sub-module: sb_cfg_shifter, a 32-bit load/shift register with bit counter, empty flag and last-bit flag. The FSM and counters stay in the top module.

Test Plan:
- NUM_SB=4, 4 words 32'hA5A5_0001, 32'h0000_FFFF, 32'h1234_5678, 32'hDEAD_BEEF with cfg_valid held high -> exactly 128 consecutive prog_en cycles and done at cycle 130 after start. A behavioural 4-SB chain model then holds SB0=32'hDEAD_BEEF and SB3=32'hA5A5_0001.
- Same load with a 10-cycle gap in cfg_valid after word 2 -> prog_en=0 for the gap and identical final chain contents. Total prog_en cycles = 128.
- start pulsed while busy (e.g. mid-word-3) -> word_cnt and state unchanged; no second done.
- rst_n asserted at shift cycle 50 -> prog_en, busy and cfg_ready go to 0 in the same cycle (async). A subsequent full load is correct.
- SB_CFG_READBACK_EN with a correct chain model -> VERIFY lasts 128 cycles, cfg_err=0, and chain contents are unchanged after done.
- SB_CFG_READBACK_EN with chain_in forced inverted for one bit -> cfg_err=1 at done; the next start clears cfg_err.
